xgmii_delay_unpack: RTL
=======================

// Module: xgmii_delay_unpack
// PURPOSE
//  Downstream consumer of the 144-bit delay-line TX FIFO (clk156 side).
//  - Holds traffic for a programmed delay after link-up.
//  - Then unpacks each 144-bit word into two 72-bit XGMII beats, low half first, onto port 1 TX.
//  - Replaces the ad-hoc toggle/rx_tmp logic.
//  - Emits legal XGMII idle whenever no data is available.
// PARAMETERS
//  DELAY_CYCLES  200  clk156 cycles between link-up and first FIFO read; 0 = no wait
//  CNT_W         16   width of underrun counter
// PORTS
//  clk156        in   1    156.25 MHz XGMII clock, single clock domain
//  sys_rst_n     in   1    synchronous reset, active low
//  link_up       in   1    GT tx_resetdone; low forces WAIT_LINK
//  fifo_dout     in   144  FWFT FIFO word: [71:0]=beat0 {txd,txc}, [143:72]=beat1 {txd,txc}
//  fifo_empty    in   1    FIFO empty flag
//  fifo_rd_en    out  1    FIFO pop, combinational
//  xgmii_txd     out  64   TX data, registered
//  xgmii_txc     out  8    TX control, registered
//  running       out  1    high in RUN state
//  underrun_cnt  out  CNT_W  saturating underrun count
// BEHAVIOUR
//  Idle word: txd=64'h0707_0707_0707_0707, txc=8'hFF.
//    Beat format: bits [71:8] = txd, bits [7:0] = txc.
//  Reset (sys_rst_n=0 at posedge):
//    state=WAIT_LINK, phase=0, timer=0, hold=0, underrun_cnt=0,
//    running=0, xgmii outputs=idle.
//  fifo_rd_en = (state==RUN) & (phase==0) & ~fifo_empty; never asserted otherwise.
//  States:
//    WAIT_LINK: outputs idle; link_up=1 -> DELAY, timer cleared.
//    DELAY: outputs idle; timer+1 each cycle.
//      Moves to RUN on the cycle timer==DELAY_CYCLES-1.
//      DELAY_CYCLES=0 goes WAIT_LINK -> RUN directly.
//    RUN, phase 0, FIFO non-empty:
//      pop; next cycle xgmii = fifo_dout[71:0].
//      hold <= fifo_dout[143:72]; phase -> 1.
//    RUN, phase 1:
//      next cycle xgmii = hold; phase -> 0; FIFO ignored.
//    RUN, phase 0, FIFO empty (underrun):
//      next cycle xgmii = idle; phase stays 0; underrun event.
//  Latency: one cycle from pop to beat0 on XGMII; beat1 follows on the next cycle.
//    Steady state gives one pop every 2 cycles.
//  link_up=0 in any state:
//    next state WAIT_LINK, phase=0, outputs idle from next cycle.
//    A pending hold beat is discarded. underrun_cnt is kept.
//  Reset mid-RUN: identical to power-up reset; a held half-word is dropped.
//  DELAY timer width = $clog2(DELAY_CYCLES+1), minimum 1.
//  Timer restarts from 0 on every link re-acquire.
//  running = registered (state==RUN).
// CONFIGURATION
//  XGMII_UNDERRUN_CNT_EN defined:
//    underrun_cnt += 1 per underrun event.
//    Saturates at all-ones; cleared only by reset.
//  XGMII_UNDERRUN_CNT_EN undefined:
//    underrun_cnt tied to 0; no counter flops.
//    Datapath behaviour is identical in both cases.
// TESTING
//  1 Reset, link_up=0, FIFO non-empty -> fifo_rd_en=0; txd=0707..07, txc=FF indefinitely.
//  2 DELAY_CYCLES=200, link_up rises at cycle T
//      -> running=1 and first fifo_rd_en at T+201 (WAIT_LINK->DELAY 1 cycle, +200 DELAY);
//      -> no pop earlier.
//  3 FIFO words W0={A1,A0}, W1={B1,B0} preloaded
//      -> XGMII beats A0,A1,B0,B1 on consecutive cycles;
//      -> then idle; exactly 2 pops, spaced 2 cycles apart.
//  4 FIFO empty for 5 RUN phase-0 cycles (counter macro on)
//      -> 5 idle beats, underrun_cnt=5;
//      -> with macro off, underrun_cnt=0, same XGMII output.
//  5 link_up drops the cycle after W0 is popped
//      -> A0 still emitted, A1 discarded, then idle;
//      -> on relink, the full DELAY_CYCLES wait repeats.
//  6 CNT_W=4, 20 underruns -> underrun_cnt holds 4'hF; reset mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/xgmii_delay_unpack.sv
// Purpose : drains the 144-bit delay-line TX FIFO onto XGMII after a fixed post-link-up delay.
//           Each word is split into two 72-bit beats, low half first. Idle is emitted when no data is available.
// Latency : 1 cycle from FIFO pop to beat0 on XGMII; beat1 follows on the next cycle (one pop per 2 cycles).
// Backpr. : none downstream; FIFO is FWFT and popped combinationally, and an empty FIFO in phase 0 yields idle (underrun).
//
// Ports:
//   clk156_i        156.25 MHz XGMII clock (single domain)
//   sys_rst_n_i     synchronous active-low reset
//   link_up_i       GT tx_resetdone; low forces WAIT_LINK and drops any held half-word
//   fifo_dout_i     FWFT word: [71:0] = beat0 {txd,txc}, [143:72] = beat1 {txd,txc}
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_en_o    FIFO pop (combinational)
//   xgmii_txd_o     registered TX data
//   xgmii_txc_o     registered TX control
//   running_o       registered "state is RUN"
//   underrun_cnt_o  saturating underrun count
//
// Build option: define XGMII_UNDERRUN_CNT_EN to enable the underrun counter; otherwise it reads 0.
module xgmii_delay_unpack #(
  parameter int DELAY_CYCLES = 200,
  parameter int CNT_W        = 16
) (
  input  logic               clk156_i,
  input  logic               sys_rst_n_i,
  input  logic               link_up_i,
  input  logic [143:0]       fifo_dout_i,
  input  logic               fifo_empty_i,
  output logic               fifo_rd_en_o,
  output logic [63:0]        xgmii_txd_o,
  output logic [7:0]         xgmii_txc_o,
  output logic               running_o,
  output logic [CNT_W-1:0]   underrun_cnt_o
);

  localparam int TW = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);
  // Last DELAY-state timer value; meaningless (and unreachable) when DELAY_CYCLES is 0.
  localparam logic [TW-1:0] TLAST = TW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
  localparam logic [71:0] IDLE_BEAT = {64'h0707_0707_0707_0707, 8'hFF};

  typedef enum logic [1:0] {WAIT_LINK, DELAY, RUN} state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [71:0]   hold_q,  hold_d;
  logic [71:0]   beat_q,  beat_d;
  logic          running_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    beat_d       = IDLE_BEAT;
    // The pop does not look at link_up: a word popped while the link drops is lost on purpose.
    fifo_rd_en_o = (state_q == RUN) && !phase_q && !fifo_empty_i;

    if (!link_up_i) begin
      // Stale hold_q is harmless: phase 0 never reads it.
      state_d = WAIT_LINK;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LINK: begin
          timer_d = '0;
          state_d = (DELAY_CYCLES == 0) ? RUN : DELAY;
        end
        DELAY: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TLAST) state_d = RUN;
        end
        RUN: begin
          if (phase_q) begin
            beat_d  = hold_q;
            phase_d = 1'b0;
          end else if (!fifo_empty_i) begin
            beat_d  = fifo_dout_i[71:0];
            hold_d  = fifo_dout_i[143:72];
            phase_d = 1'b1;
          end
        end
        default: state_d = WAIT_LINK;
      endcase
    end
  end

  always_ff @(posedge clk156_i) begin
    if (!sys_rst_n_i) begin
      state_q   <= WAIT_LINK;
      phase_q   <= 1'b0;
      timer_q   <= '0;
      hold_q    <= '0;
      beat_q    <= IDLE_BEAT;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      beat_q    <= beat_d;
      running_q <= (state_d == RUN);
    end
  end

  assign xgmii_txd_o = beat_q[71:8];
  assign xgmii_txc_o = beat_q[7:0];
  assign running_o   = running_q;

`ifdef XGMII_UNDERRUN_CNT_EN
  logic             underrun;
  logic [CNT_W-1:0] cnt_q;

  assign underrun = link_up_i && (state_q == RUN) && !phase_q && fifo_empty_i;

  always_ff @(posedge clk156_i) begin
    if (!sys_rst_n_i) begin
      cnt_q <= '0;
    end else if (underrun && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign underrun_cnt_o = cnt_q;
`else
  assign underrun_cnt_o = '0;
`endif

endmodule
